rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the writeback stage and one long-latency unit (multiply/divide, etc.) that completes out of band. Writeback writes always pass through in the same cycle. Long-latency results queue in a small FIFO and drain into idle write-port cycles. If the FIFO head waits too long, the block requests a pipeline halt so the head can drain. It sits between the writeback stage, the long-latency unit and the register file, and exports a pending-register mask for the issue scoreboard.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive denied cycles before stall_req asserts; 1..15.

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- halt  in  1  pipeline halted; writeback inputs repeat the same instruction while high.
- wb_we  in  1  writeback write request.
- wb_tgt  in  3  writeback target register.
- wb_data  in  16  writeback result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_tgt  in  3  long-latency target register.
- lu_data  in  16  long-latency result.
- rf_we  out  1  register-file write enable (combinational).
- rf_tgt  out  3  register-file write target (combinational).
- rf_data  out  16  register-file write data (combinational).
- stall_req  out  1  halt request to the pipeline.
- pend_mask  out  8  bit i set while any FIFO entry targets register i.

## Operation
- Effective writeback request: wb_req = wb_we & (wb_tgt != 0).
- Write-port grant:
  - fifo_grant = !empty & (halt | !wb_req).
  - wb_grant = wb_req & !fifo_grant.
  - While halt=1, the suppressed writeback write is safe to drop: it is re-presented after halt releases.
- Port drive:
  - fifo_grant: rf_we=1, rf_tgt/rf_data come from the FIFO head; head pops at the clock edge.
  - wb_grant: rf_we=1, rf_tgt/rf_data = wb_tgt/wb_data.
  - Neither: rf_we=0, rf_tgt=0, rf_data=0.
- Push:
  - A push happens when lu_valid & lu_ready.
  - If lu_tgt==0, the handshake completes but the result is discarded and nothing is enqueued.
- lu_ready = rst_n & (count < DEPTH).
  - It depends only on the registered count, so there is no push while the FIFO is full, even if it pops in the same cycle.
- Simultaneous push and pop (FIFO not full) is legal: count is unchanged and ordering is preserved.
- FIFO storage:
  - Circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- pend_mask:
  - OR over valid entries of onehot(tgt), recomputed from registered state.
  - A pushed entry is visible the cycle after the push; a popped entry clears the cycle after the pop.
- Starvation counter starve_cnt, 4 bits, saturating at 15:
  - Clears to 0 on any pop, and whenever the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and fifo_grant=0.
- stall_req = (starve_cnt >= STARVE_LIMIT), decoded from the registered count.
  - Stays high until the head pops.
  - The pipeline answers by raising halt, which forces fifo_grant.

## Timing
- Writeback path: zero latency, combinational to rf_*.
- FIFO write: a result accepted at edge N becomes the head and is eligible for grant in cycle N+1 at the earliest.
- Best case (wb idle, FIFO empty), a long-latency result reaches the register file one cycle after its handshake.
- Starvation: the head waits STARVE_LIMIT denied cycles, then stall_req is high in the next cycle. The head drains in the first cycle halt=1.
- Reset (rst_n=0 at an edge):
  - count=0, pointers=0, starve_cnt=0.
  - Outputs after that edge: lu_ready=0 while rst_n=0, stall_req=0, pend_mask=0.
  - rf_we is forced to 0 while rst_n=0.
- Reset mid-operation discards all queued entries without writing them. lu_ready returns to 1 in the first cycle with rst_n=1.
- lu_data and lu_tgt are sampled only on the handshake edge.

## Test plan
- Pass-through: FIFO empty, wb_we=1, wb_tgt=3, wb_data=0x1234 -> same cycle rf_we=1, rf_tgt=3, rf_data=0x1234. Repeat with wb_tgt=0 -> rf_we=0.
- Idle drain: wb_we=0, push lu_tgt=5, lu_data=0xBEEF -> next cycle pend_mask=0x20, rf_we=1, rf_tgt=5, rf_data=0xBEEF. Following cycle pend_mask=0x00.
- Full/ordering (DEPTH=2):
  - Hold wb_we=1 (tgt=1) and push tgt=2/0x0002 then tgt=4/0x0004 -> lu_ready=0, pend_mask=0x14.
  - Drop wb_we -> rf writes r2 then r4 in consecutive cycles, and lu_ready returns to 1 after the first pop.
- Starvation (STARVE_LIMIT=4):
  - Hold wb_we=1 and push one entry -> stall_req rises after 4 denied cycles.
  - Raise halt -> that cycle the FIFO entry is written, the wb write is suppressed, and stall_req falls the next cycle.
- Zero target / wrap: push lu_tgt=0 -> handshake completes, pend_mask stays 0, no rf write. Then 5 back-to-back push/drain pairs -> pointers wrap and data stays in order.
- Reset mid-operation: two entries queued, stall_req=1, pulse rst_n=0 for one cycle -> count=0, stall_req=0, pend_mask=0, no rf write of the queued data, lu_ready=1 the cycle after rst_n returns to 1.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between writeback (pass-through)
// and a small FIFO of long-latency results, with starvation-driven halt requests.
module rf_write_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt,
   input  logic        wb_we,
   input  logic [2:0]  wb_tgt,
   input  logic [15:0] wb_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [2:0]  lu_tgt,
   input  logic [15:0] lu_data,
   output logic        rf_we,
   output logic [2:0]  rf_tgt,
   output logic [15:0] rf_data,
   output logic        stall_req,
   output logic [7:0]  pend_mask
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [3:0]  LIMIT      = 4'(STARVE_LIMIT);

   logic [2:0]       tgt_q  [DEPTH];
   logic [15:0]      data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic [3:0]       starve_cnt;

   logic empty;
   logic wb_req;
   logic fifo_grant;
   logic wb_grant;
   logic push;
   logic pop;

   assign empty      = (count == '0);
   assign wb_req     = wb_we & (wb_tgt != 3'd0);
   // Halt means writeback will be re-presented later, so the FIFO may take the port.
   assign fifo_grant = !empty & (halt | !wb_req);
   assign wb_grant   = wb_req & !fifo_grant;

   assign lu_ready = rst_n & (count < FULL_COUNT);
   assign push     = lu_valid & lu_ready & (lu_tgt != 3'd0);
   assign pop      = rst_n & fifo_grant;

   assign stall_req = (starve_cnt >= LIMIT);

   always_comb begin
      rf_we   = 1'b0;
      rf_tgt  = 3'd0;
      rf_data = 16'd0;
      if (rst_n && fifo_grant) begin
         rf_we   = 1'b1;
         rf_tgt  = tgt_q[rd_ptr];
         rf_data = data_q[rd_ptr];
      end else if (rst_n && wb_grant) begin
         rf_we   = 1'b1;
         rf_tgt  = wb_tgt;
         rf_data = wb_data;
      end
   end

   always_comb begin
      pend_mask = 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) pend_mask = pend_mask | (8'b1 << tgt_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tgt_q[wr_ptr]  <= lu_tgt;
         data_q[wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= 4'd0;
      end else begin
         if (push) begin
            valid_q[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop || empty)
            starve_cnt <= 4'd0;
         else if (starve_cnt != 4'd15)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; queued long-latency results are
// tracked in a scoreboard and compared when they reach the register file.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halt;
   logic        wb_we;
   logic [2:0]  wb_tgt;
   logic [15:0] wb_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [2:0]  lu_tgt;
   logic [15:0] lu_data;
   logic        rf_we;
   logic [2:0]  rf_tgt;
   logic [15:0] rf_data;
   logic        stall_req;
   logic [7:0]  pend_mask;

   int checks = 0;
   int errors = 0;
   logic [18:0] sb[$];

   rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .wb_we(wb_we), .wb_tgt(wb_tgt), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_tgt(lu_tgt), .lu_data(lu_data),
      .rf_we(rf_we), .rf_tgt(rf_tgt), .rf_data(rf_data),
      .stall_req(stall_req), .pend_mask(pend_mask)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic lu_push(input logic [2:0] t, input logic [15:0] d);
      lu_valid = 1'b1;
      lu_tgt   = t;
      lu_data  = d;
      if (t != 3'd0) sb.push_back({t, d});
   endtask

   task automatic chk_pop(input string tag);
      logic [18:0] e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed rf write with empty scoreboard, expected none", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_we"}, 32'(rf_we), 32'd1);
         chk({tag, "_tgt"}, 32'(rf_tgt), 32'(e[18:16]));
         chk({tag, "_data"}, 32'(rf_data), 32'(e[15:0]));
      end
   endtask

   initial begin
      rst_n = 1'b0; halt = 1'b0; wb_we = 1'b0; wb_tgt = 3'd0; wb_data = 16'd0;
      lu_valid = 1'b0; lu_tgt = 3'd0; lu_data = 16'd0;
      tick; tick;
      chk("rst_lu_ready", 32'(lu_ready), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_pend", 32'(pend_mask), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      rst_n = 1'b1;
      #1 chk("rel_lu_ready", 32'(lu_ready), 32'd1);

      // pass-through
      tick;
      wb_we = 1'b1; wb_tgt = 3'd3; wb_data = 16'h1234;
      #1;
      chk("pt_we", 32'(rf_we), 32'd1);
      chk("pt_tgt", 32'(rf_tgt), 32'd3);
      chk("pt_data", 32'(rf_data), 32'h1234);
      wb_tgt = 3'd0;
      #1;
      chk("pt_r0_we", 32'(rf_we), 32'd0);
      chk("pt_r0_data", 32'(rf_data), 32'd0);
      wb_we = 1'b0;

      // idle drain
      tick;
      lu_push(3'd5, 16'hBEEF);
      #1 chk("idle_no_we", 32'(rf_we), 32'd0);
      tick;
      lu_valid = 1'b0;
      #1;
      chk("idle_pend", 32'(pend_mask), 32'h20);
      chk_pop("idle_drain");
      tick;
      chk("idle_pend_clr", 32'(pend_mask), 32'h00);
      chk("idle_we_clr", 32'(rf_we), 32'd0);

      // full / ordering
      wb_we = 1'b1; wb_tgt = 3'd1; wb_data = 16'h1111;
      lu_push(3'd2, 16'h0002);
      #1 chk("full_wb0", 32'(rf_tgt), 32'd1);
      tick;
      lu_push(3'd4, 16'h0004);
      #1;
      chk("full_ready1", 32'(lu_ready), 32'd1);
      chk("full_wb1", 32'(rf_tgt), 32'd1);
      tick;
      lu_valid = 1'b0;
      #1;
      chk("full_ready0", 32'(lu_ready), 32'd0);
      chk("full_pend", 32'(pend_mask), 32'h14);
      chk("full_wb2", 32'(rf_data), 32'h1111);
      wb_we = 1'b0;
      #1;
      chk_pop("ord_first");
      chk("ord_ready_still0", 32'(lu_ready), 32'd0);
      tick;
      chk_pop("ord_second");
      chk("ord_ready_back", 32'(lu_ready), 32'd1);
      chk("ord_pend", 32'(pend_mask), 32'h10);
      tick;
      chk("ord_idle", 32'(rf_we), 32'd0);
      chk("ord_pend_clr", 32'(pend_mask), 32'd0);
      chk("ord_no_stall", 32'(stall_req), 32'd0);

      // starvation
      wb_we = 1'b1; wb_tgt = 3'd1; wb_data = 16'h7777;
      lu_push(3'd6, 16'h6666);
      tick;
      lu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("starve_low", 32'(stall_req), 32'd0);
         chk("starve_wb", 32'(rf_data), 32'h7777);
         tick;
      end
      chk("starve_high", 32'(stall_req), 32'd1);
      halt = 1'b1;
      #1;
      chk_pop("starve_drain");
      tick;
      halt = 1'b0;
      #1;
      chk("starve_fall", 32'(stall_req), 32'd0);
      chk("starve_wb_back", 32'(rf_tgt), 32'd1);
      wb_we = 1'b0;

      // zero target
      tick;
      lu_push(3'd0, 16'hDEAD);
      #1 chk("zt_ready", 32'(lu_ready), 32'd1);
      tick;
      lu_valid = 1'b0;
      #1;
      chk("zt_pend", 32'(pend_mask), 32'd0);
      chk("zt_no_we", 32'(rf_we), 32'd0);

      // pointer wrap
      for (int i = 0; i < 5; i++) begin
         lu_push(3'((i % 7) + 1), 16'hA000 + 16'(i));
         tick;
         lu_valid = 1'b0;
         #1;
         chk("wrap_pend", 32'(pend_mask), 32'(8'b1 << ((i % 7) + 1)));
         chk_pop("wrap");
         tick;
      end

      // reset mid-operation
      wb_we = 1'b1; wb_tgt = 3'd1; wb_data = 16'h0101;
      lu_push(3'd3, 16'h3333);
      tick;
      lu_push(3'd7, 16'h7777);
      tick;
      lu_valid = 1'b0;
      for (int i = 0; i < 10 && !stall_req; i++) tick;
      chk("rmo_stall", 32'(stall_req), 32'd1);
      chk("rmo_pend", 32'(pend_mask), 32'h88);
      rst_n = 1'b0; wb_we = 1'b0;
      #1;
      chk("rmo_we_forced", 32'(rf_we), 32'd0);
      chk("rmo_ready_low", 32'(lu_ready), 32'd0);
      tick;
      chk("rmo_stall_clr", 32'(stall_req), 32'd0);
      chk("rmo_pend_clr", 32'(pend_mask), 32'd0);
      rst_n = 1'b1;
      sb.delete();
      #1;
      chk("rmo_ready_back", 32'(lu_ready), 32'd1);
      chk("rmo_no_write", 32'(rf_we), 32'd0);
      tick;
      chk("rmo_no_write2", 32'(rf_we), 32'd0);
      chk("rmo_pend2", 32'(pend_mask), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
